// File: rtl/apb_uart_tx.sv
// rtl/apb_uart_tx.sv - APB-slave UART transmitter with TX FIFO and programmable bit period (optional parity: UART_TX_PARITY_EN)
module apb_uart_tx #(
    parameter int DEPTH   = 4,
    parameter int DEF_DIV = 286,
    parameter int DIV_W   = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        pslverr,
    output logic        serial_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // Register-side decode
    logic [3:0]       addr;
    logic             access;
    logic             is_tx;
    logic             is_stat;
    logic             is_div;
    logic             div_ok;
    logic             div_we;
    logic [DIV_W-1:0] div_q;
    logic [31:0]      status;
    logic             busy;

    // Frame engine
    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [DIV_W-1:0] bitdiv_q, bitdiv_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic             bit_end;
    logic             load;
    logic             serial_d;

`ifdef UART_TX_PARITY_EN
    logic             par_ctrl_q;
    logic             par_on_q, par_on_d;
    logic             par_bit_q, par_bit_d;
`endif

    logic             unused_ok;
    assign unused_ok = ^{PADDR[31:4], PWDATA[31:DIV_W]};

    assign addr    = PADDR[3:0];
    assign access  = PSEL & PENABLE;
    assign is_tx   = (addr == 4'h0);
    assign is_stat = (addr == 4'h4);
    assign is_div  = (addr == 4'h8);
    assign div_ok  = (PWDATA[DIV_W-1:0] >= DIV_W'(2));

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign busy  = (state_q != S_IDLE);

    // A full FIFO still takes a byte when the frame engine frees a slot this cycle.
    assign push   = access & PWRITE & is_tx & (~full | pop);
    assign div_we = access & PWRITE & is_div & div_ok;

`ifdef UART_TX_PARITY_EN
    assign status = {23'd0, par_ctrl_q, 4'(count), 1'b0, busy, full, empty};
`else
    assign status = {23'd0, 1'b0, 4'(count), 1'b0, busy, full, empty};
`endif

    // Error response for the current access cycle; errored accesses have no side effect
    always_comb begin
        pslverr = 1'b0;
        if (access) begin
            if (!(is_tx || is_stat || is_div))
                pslverr = 1'b1;
            else if (PWRITE && is_tx && full && !pop)
                pslverr = 1'b1;
            else if (PWRITE && is_div && !div_ok)
                pslverr = 1'b1;
        end
    end

    // Read mux, live whenever the slave is selected for a read
    always_comb begin
        PRDATA = 32'd0;
        if (PSEL && !PWRITE) begin
            if (is_stat)
                PRDATA = status;
            else if (is_div)
                PRDATA = 32'(div_q);
        end
    end

    // Divisor and parity control registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_q <= DIV_W'(DEF_DIV);
        end else if (div_we) begin
            div_q <= PWDATA[DIV_W-1:0];
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity enable bit shares the STATUS offset on the write side
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            par_ctrl_q <= 1'b0;
        else if (access && PWRITE && is_stat)
            par_ctrl_q <= PWDATA[8];
    end
`endif

    // FIFO data array; contents are meaningless until counted in
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= PWDATA[7:0];
    end

    // FIFO pointers and occupancy; reset discards everything queued
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bit_end = (baud_q == bitdiv_q - DIV_W'(1));

    // Frame FSM next state; a pop from IDLE or at the end of STOP starts a frame
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitdiv_d = bitdiv_q;
        bitcnt_d = bitcnt_q;
        load     = 1'b0;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_on_d  = par_on_q;
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty)
                    load = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d  = S_DATA;
                    bitcnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_on_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end)
                    state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (!empty)
                        load = 1'b1;
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            pop      = 1'b1;
            state_d  = S_START;
            shift_d  = mem[rd_ptr];
            bitdiv_d = div_q;
`ifdef UART_TX_PARITY_EN
            par_on_d  = par_ctrl_q;
            par_bit_d = ^mem[rd_ptr];
`endif
        end

        baud_d = (state_q == S_IDLE || bit_end) ? '0 : baud_q + DIV_W'(1);

        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: serial_d = par_bit_d;
`endif
            default:  serial_d = 1'b1;
        endcase
    end

    // Frame FSM registers; the line output is a flop so it never glitches
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'd0;
            bitdiv_q   <= DIV_W'(DEF_DIV);
            baud_q     <= '0;
            bitcnt_q   <= 3'd0;
            serial_out <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_on_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitdiv_q   <= bitdiv_d;
            baud_q     <= baud_d;
            bitcnt_q   <= bitcnt_d;
            serial_out <= serial_d;
`ifdef UART_TX_PARITY_EN
            par_on_q   <= par_on_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_uart_tx.sv
// tb/tb_apb_uart_tx.sv - scoreboard bench for apb_uart_tx with a serial-line monitor
module tb_apb_uart_tx;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        pslverr;
    logic        serial_out;

    apb_uart_tx dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PENABLE    (PENABLE),
        .PSEL       (PSEL),
        .PRDATA     (PRDATA),
        .pslverr    (pslverr),
        .serial_out (serial_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         par;
    } exp_t;

    exp_t exp_q[$];
    int   starts[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Each access: one setup cycle, one access cycle; called and returns just after a negedge
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge clk);
        PENABLE = 1'b1;
        #1 err = pslverr;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge clk);
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                      input logic exp_err);
        logic e;
        apb_write(addr, data, e);
        chk(name, e, exp_err);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] req);
        logic [31:0] d;
        apb_read(addr, d);
        chk(name, d, req);
    endtask

    task automatic send(input string name, input logic [7:0] b, input int div, input bit par);
        exp_q.push_back('{data: b, div: div, par: par});
        wr(name, 32'h0, {24'd0, b}, 1'b0);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain(input string name, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy) break;
        end
        chk(name, (i < limit), 1);
    endtask

    // Line monitor: receives each frame and checks it against the oldest expected byte
    initial begin : monitor
        exp_t       e;
        logic [10:0] bits;
        bit         tbad;
        bit         aborted;
        int         nb;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && serial_out === 1'b0) begin
                starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=start_bit required=idle_line at cycle %0d", cyc);
                    for (int i = 0; i < 4000; i++) begin
                        @(negedge clk);
                        if (serial_out === 1'b1) break;
                    end
                end else begin
                    e        = exp_q.pop_front();
                    mon_busy = 1'b1;
                    nb       = e.par ? 11 : 10;
                    tbad     = 1'b0;
                    aborted  = 1'b0;
                    bits     = '0;
                    for (int b = 0; b < nb && !aborted; b++) begin
                        for (int k = 0; k < e.div && !aborted; k++) begin
                            if (b != 0 || k != 0) @(negedge clk);
                            if (n_rst !== 1'b1)
                                aborted = 1'b1;
                            else if (k == 0)
                                bits[b] = serial_out;
                            else if (serial_out !== bits[b])
                                tbad = 1'b1;
                        end
                    end
                    if (!aborted) begin
                        chk("rx_start", bits[0], 0);
                        chk("rx_data", bits[8:1], e.data);
                        if (e.par) chk("rx_parity", bits[9], ^e.data);
                        chk("rx_stop", bits[nb-1], 1);
                        chk("rx_bit_timing", tbad, 0);
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=still_running required=finished at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cf;
        int low;
        n_rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd0; PWDATA = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_serial", serial_out, 1);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_prdata", PRDATA, 0);
        n_rst = 1'b1;
        @(negedge clk);
        rd("rst_status", 32'h4, 32'h01);
        rd("rst_div", 32'h8, 32'd286);
        wr("bad_offset", 32'hC, 32'h1, 1'b1);

        // Single frame 0xA9 at default divisor, exact start latency and frame length
        send("t1_write", 8'hA9, 286, 1'b0);
        cf = cyc + 1;
        chk("t1_line_high_after_access", serial_out, 1);
        @(negedge clk);
        chk("t1_start_fall", serial_out, 0);
        wait_cyc(cf + 2857);
        rd("t1_status_last_cycle", 32'h4, 32'h05);
        rd("t1_status_idle", 32'h4, 32'h01);
        drain("t1_drain", 200);

        // Back-to-back frames must be contiguous
        starts.delete();
        send("t2_w0", 8'h6A, 286, 1'b0);
        send("t2_w1", 8'h55, 286, 1'b0);
        send("t2_w2", 8'h00, 286, 1'b0);
        rd("t2_status", 32'h4, 32'h24);
        drain("t2_drain", 9000);
        chk("t2_frame_count", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("t2_gap01", starts[1] - starts[0], 2860);
            chk("t2_gap12", starts[2] - starts[1], 2860);
        end

        // FIFO full: overflow rejected, push in the pop cycle accepted
        send("t3_a", 8'h11, 286, 1'b0);
        cf = cyc + 1;
        send("t3_b", 8'h22, 286, 1'b0);
        send("t3_c", 8'h33, 286, 1'b0);
        send("t3_d", 8'h44, 286, 1'b0);
        send("t3_e", 8'h88, 286, 1'b0);
        rd("t3_status_full", 32'h4, 32'h46);
        wr("t3_overflow", 32'h0, 32'hEE, 1'b1);
        wait_cyc(cf + 2858);
        send("t3_pop_cycle_push", 8'h99, 286, 1'b0);
        drain("t3_drain", 20000);

        // Divisor change mid-frame applies to the next frame only
        send("t4_a", 8'h3C, 286, 1'b0);
        wr("t4_div16", 32'h8, 32'd16, 1'b0);
        send("t4_b", 8'h81, 16, 1'b0);
        wr("t4_div1", 32'h8, 32'd1, 1'b1);
        rd("t4_div_readback", 32'h8, 32'd16);
        drain("t4_drain", 4000);

        // Reset during data bit 3 (a 0 bit of 0x96)
        send("t5_a", 8'h96, 16, 1'b0);
        cf = cyc + 1;
        wr("t5_b", 32'h0, 32'h11, 1'b0);
        wait_cyc(cf + 69);
        n_rst = 1'b0;
        #1 chk("t5_async_high", serial_out, 1);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        rd("t5_status", 32'h4, 32'h01);
        rd("t5_div", 32'h8, 32'd286);
        low = 0;
        repeat (600) begin
            @(negedge clk);
            if (serial_out !== 1'b1) low++;
        end
        chk("t5_line_idle", low, 0);
        send("t5_after", 8'h5A, 286, 1'b0);
        drain("t5_drain", 4000);

`ifdef UART_TX_PARITY_EN
        // Even parity after bit 7, frame of 11 bits
        wr("t6_div16", 32'h8, 32'd16, 1'b0);
        wr("t6_par_on", 32'h4, 32'h100, 1'b0);
        rd("t6_status_par", 32'h4, 32'h101);
        starts.delete();
        send("t6_byte", 8'h07, 16, 1'b1);
        send("t6_next", 8'hC3, 16, 1'b1);
        drain("t6_drain", 1000);
        if (starts.size() == 2)
            chk("t6_frame_len", starts[1] - starts[0], 176);
        else
            chk("t6_frame_count", starts.size(), 2);
`else
        wr("t6_status_write", 32'h4, 32'h100, 1'b0);
        rd("t6_status_nopar", 32'h4, 32'h01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_uart_tx.md
Name: apb_uart_tx

Overview:
APB-slave UART transmitter: the transmit-side counterpart to the team's serial receive slave on the same AHB-to-APB bridge. Software writes bytes into a small TX FIFO over APB. A frame FSM serialises them LSB-first as start/8 data/stop frames on serial_out, with a programmable bit period. A receiver configured for the same bit period recovers every byte.

Parameters:
DEPTH, 4, TX FIFO entries (power of 2, >=2)
DEF_DIV, 286, reset value of the bit-period divisor, in clk cycles per bit
DIV_W, 16, divisor register width

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
PADDR  in  32  APB address; only PADDR[3:0] decoded
PWDATA  in  32  APB write data
PWRITE  in  1  APB write strobe
PENABLE  in  1  APB access phase
PSEL  in  1  slave select (one PSEL_slave bit from the bridge)
PRDATA  out  32  APB read data
pslverr  out  1  APB error response
serial_out  out  1  UART line, idle high

Behaviour:
- Reset: serial_out=1, pslverr=0, PRDATA=0, FIFO empty, FSM=IDLE, divisor=DEF_DIV.
- Accesses are valid only when PSEL&PENABLE, which is the single access cycle; there are no wait states.
- Register map:
  - 0x0 TXDATA, write-only: PWDATA[7:0] pushed to FIFO. Reads return 0.
  - 0x4 STATUS, read-only: {count[3:0] at bits 7:4, busy[2], full[1], empty[0]}. Writes are ignored with no error.
  - 0x8 DIV, read/write: bit period in clocks, DIV_W bits.
- pslverr, combinational in the access cycle, is asserted for:
  - a write to TXDATA when the FIFO is full and no pop happens that cycle;
  - a write of DIV < 2;
  - any access to an unmapped offset.
  An errored access has no side effect.
- PRDATA is combinational: valid when PSEL&!PWRITE, otherwise 0.
- FIFO behaviour:
  - Push and pop can occur in the same cycle. When full, a push is accepted only if a pop occurs that same cycle.
  - count is 0..DEPTH. Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: serial_out=1. If the FIFO is non-empty, pop the byte into a shift register, latch the divisor into bitdiv, and go to START on the next edge. serial_out falls on that edge.
  - START: drive 0 for bitdiv clocks.
  - DATA: drive shift[0], shifting right each bit period. Bit counter runs 0..7; after bit 7 go to STOP (or PARITY).
  - STOP: drive 1 for bitdiv clocks. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Each bit is held exactly bitdiv cycles. A baud counter counts 0..bitdiv-1 and wraps.
- Frame length is 10*bitdiv clocks (11*bitdiv with parity).
- busy = (state != IDLE).
- A DIV write mid-frame does not affect the current frame; it takes effect at the next pop.
- Reset asserted mid-frame: serial_out returns to 1 asynchronously and all FIFO contents are discarded.
- serial_out is driven from a flop, so it is glitch-free.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - Adds a PARITY state between DATA and STOP that drives the even-parity bit (XOR of the 8 data bits) for bitdiv clocks.
  - Adds a control bit, STATUS write bit 8: 1 = parity on (reset 0). With this macro, writes to 0x4 bit 8 are therefore stored, not ignored.
  - STATUS read bit 8 reflects that control bit.
  - The setting is latched at pop time, like the divisor.
- Undefined: no PARITY state, STATUS bit 8 reads 0, and the write is ignored.

Test Plan:
- Reset, then write 0xA9 to 0x0 with default DIV.
  - serial_out falls 2 clocks after the write access.
  - Bits 0,1,0,0,1,0,1,0,1 follow (data LSB first), each exactly 286 clocks, then stop=1.
  - Back in IDLE with busy=0 after 2860 clocks.
- Write 0x6A, 0x55, 0x00 back-to-back.
  - STATUS read shows count=2, busy=1.
  - Frames are contiguous, with no high gap between a stop bit and the next start bit.
  - Loopback into the serial receive slave at 286 recovers all three bytes.
- Fill the FIFO: 5 writes while the first frame is sending.
  - The write that finds count=4 gets pslverr=1, and that byte is never transmitted.
  - A write landing in the pop cycle of a full FIFO is accepted with pslverr=0.
- Write DIV=16 mid-frame.
  - The current frame stays at 286 clocks/bit; the next frame runs at 16 clocks/bit.
  - Writing DIV=1 gives pslverr=1, and DIV reads back 16.
- Assert n_rst during DATA bit 3.
  - serial_out goes high immediately; STATUS=empty, count=0.
  - No frame starts after reset release until a new write.
- With UART_TX_PARITY_EN defined and parity on, send 0x07.
  - A parity bit of 1 appears after data bit 7; the frame is 11*DIV clocks.
